// File: rtl/snoop_bus_arbiter.sv
// Shared-bus arbiter for NPROC snooping caches: urgent (hit-modified) requests first,
// round-robin within each class, hold timeout, one-cycle turnaround, arbitration enable.
module snoop_bus_arbiter #(
  parameter int NPROC    = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W    = $clog2(NPROC)
) (
  input  logic             SCLK,
  input  logic             SRST,
  input  logic             SINT,
  input  logic [NPROC-1:0] req,
  input  logic [NPROC-1:0] hitm,
  input  logic [NPROC-1:0] done,
  output logic [NPROC-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             timeout_err,
  output logic [ID_W-1:0]  err_id
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t             state_q, state_d;
  logic [NPROC-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               terr_q, terr_d;
  logic [ID_W-1:0]    errid_q, errid_d;

  logic [NPROC-1:0]   urg;
  logic [NPROC-1:0]   cand;
  logic [ID_W-1:0]    win;
  logic               win_found;

  // Rotating scan starting just above the last winner; urgent set replaces req when non-empty.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    urg       = req & hitm;
    cand      = (urg != '0) ? urg : req;
    win       = '0;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= NPROC; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NPROC) idx = idx - NPROC;
      if (!win_found && cand[idx]) begin
        win       = ID_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    errid_d = errid_q;
    case (state_q)
      IDLE: begin
        if (SINT && win_found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          rr_d         = win;
          cnt_d        = CNT_W'(1);
          state_d      = OWNED;
        end
      end
      OWNED: begin
        // A release at the timeout edge takes precedence and suppresses the error.
        if (done[owner_q] || !req[owner_q]) begin
          grant_d = '0;
          state_d = TURN;
        end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          grant_d = '0;
          terr_d  = 1'b1;
          errid_d = owner_q;
          state_d = TURN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (SRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= ID_W'(NPROC - 1);
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      errid_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      errid_q <= errid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = grant_valid ? owner_q : '0;
  assign timeout_err = terr_q;
  assign err_id      = errid_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed scenarios plus randomized traffic for snoop_bus_arbiter, checked
// cycle by cycle against a behavioural model of the arbitration rules.
module tb_snoop_bus_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int IDW  = 2;
  localparam int VW   = N + 1 + IDW + 1 + IDW;

  logic           SCLK = 1'b0;
  logic           SRST = 1'b1;
  logic           SINT = 1'b1;
  logic [N-1:0]   req  = '0;
  logic [N-1:0]   hitm = '0;
  logic [N-1:0]   done = '0;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           timeout_err;
  logic [IDW-1:0] err_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  snoop_bus_arbiter #(.NPROC(N), .MAX_HOLD(HOLD)) dut (
    .SCLK(SCLK), .SRST(SRST), .SINT(SINT),
    .req(req), .hitm(hitm), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout_err(timeout_err), .err_id(err_id)
  );

  always #5 SCLK = ~SCLK;

  // Model: phase 0 = no owner, 1 = owner holds the bus, 2 = turnaround.
  int m_phase = 0, m_owner = 0, m_held = 0, m_last = N - 1, m_errid = 0;
  bit m_terr  = 1'b0;

  task automatic model_step();
    logic [N-1:0] pool;
    bit           found;
    int           c;
    if (SRST) begin
      m_phase = 0; m_owner = 0; m_held = 0; m_last = N - 1; m_terr = 0; m_errid = 0;
    end else begin
      m_terr = 0;
      if (m_phase == 0) begin
        if (SINT && req != 0) begin
          pool  = ((req & hitm) != 0) ? (req & hitm) : req;
          found = 0;
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!found && pool[c]) begin m_owner = c; found = 1; end
          end
          m_last = m_owner; m_held = 1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (done[m_owner] || !req[m_owner]) m_phase = 2;
        else if (m_held == HOLD) begin m_phase = 2; m_terr = 1; m_errid = m_owner; end
        else m_held++;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0]   g;
    logic [IDW-1:0] gid;
    g   = (m_phase == 1) ? N'(1 << m_owner) : '0;
    gid = (m_phase == 1) ? IDW'(m_owner) : '0;
    return {g, |g, gid, m_terr, IDW'(m_errid)};
  endfunction

  wire [VW-1:0] dut_vec = {grant, grant_valid, grant_id, timeout_err, err_id};

  task automatic tick();
    model_step();
    @(posedge SCLK);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    SRST = 1; SINT = 1; req = '0; hitm = '0; done = '0;
    tick();
    checks++;
    if (dut_vec !== exp_vec() || dut_vec !== '0) begin
      errors++; $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
    end
    SRST = 0;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    req = 4'b0010;
    tick();
    checks++;
    if (dut_vec !== exp_vec() || grant !== 4'b0010 || grant_id !== 2'd1 || grant_valid !== 1'b1) begin
      errors++; $display("FAIL basic_grant cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
    end
    done = 4'b0010;
    tick();
    done = '0; req = '0;
    checks++;
    if (dut_vec !== exp_vec() || grant !== 4'b0000) begin
      errors++; $display("FAIL basic_release cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
    end
    repeat (2) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec() || grant !== 4'b0000) begin
        errors++; $display("FAIL basic_turn_idle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [5];
    int zeros;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    SRST = 1; req = '0; hitm = '0; done = '0;
    tick();
    SRST = 0; req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      zeros = (j == 0) ? 0 : 1;
      for (int w = 0; w < 8 && grant == '0; w++) begin
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL rr_cycle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
        end
        if (grant == '0) zeros++;
      end
      checks++;
      if (grant !== seq[j] || zeros != ((j == 0) ? 0 : 2)) begin
        errors++;
        $display("FAIL rr_order j=%0d got=%b gap=%0d exp=%b gap=%0d", j, grant, zeros, seq[j], (j == 0) ? 0 : 2);
      end
      done = grant;
      tick();
      done = '0;
    end
    req = '0;
    tick();
  endtask

  task automatic test_urgent();
    req = 4'b0110; hitm = 4'b0100;
    for (int w = 0; w < 6 && grant == '0; w++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL urg_cycle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL urg_priority got=%b exp=%b", grant, 4'b0100);
    end
    done = 4'b0100; req = 4'b0010; hitm = '0;
    tick();
    done = '0;
    for (int w = 0; w < 6 && grant == '0; w++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL urg_cycle2 cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL urg_followup got=%b exp=%b", grant, 4'b0010);
    end
    done = 4'b0010;
    tick();
    done = '0; req = '0;
    tick();
  endtask

  task automatic test_timeout();
    int held;
    req = 4'b1000; hitm = '0;
    for (int w = 0; w < 6 && grant == '0; w++) tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++; $display("FAIL to_grant got=%b exp=%b", grant, 4'b1000);
    end
    held = 1;
    for (int w = 0; w < 20 && grant != '0; w++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL to_cycle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      if (grant != '0) held++;
    end
    checks++;
    if (held != HOLD || timeout_err !== 1'b1 || err_id !== 2'd3) begin
      errors++;
      $display("FAIL to_force held=%0d terr=%b err_id=%0d exp held=%0d terr=1 err_id=3", held, timeout_err, err_id, HOLD);
    end
    req = '0;
    tick();
    checks++;
    if (timeout_err !== 1'b0 || err_id !== 2'd3) begin
      errors++; $display("FAIL to_pulse_width terr=%b err_id=%0d exp terr=0 err_id=3", timeout_err, err_id);
    end
    req = 4'b1000;
    for (int w = 0; w < 6 && grant == '0; w++) tick();
    repeat (HOLD - 1) tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++; $display("FAIL to_hold_full got=%b exp=%b", grant, 4'b1000);
    end
    done = 4'b1000;
    tick();
    done = '0;
    checks++;
    if (dut_vec !== exp_vec() || grant !== '0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_same_edge_done got=%b exp=%b", dut_vec, exp_vec());
    end
    req = '0;
    tick();
  endtask

  task automatic test_enable_withdraw();
    SINT = 0; req = 4'b0001;
    repeat (3) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec() || grant !== '0) begin
        errors++; $display("FAIL en_blocked cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    SINT = 1;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL en_grant got=%b exp=%b", grant, 4'b0001);
    end
    req = '0;
    tick();
    checks++;
    if (dut_vec !== exp_vec() || grant !== '0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL withdraw got=%b exp=%b", dut_vec, exp_vec());
    end
    tick();
    req = 4'b0001;
    tick();
    SINT = 0;
    repeat (3) tick();
    checks++;
    if (dut_vec !== exp_vec() || grant !== 4'b0001) begin
      errors++; $display("FAIL en_owner_keeps got=%b exp=%b", dut_vec, exp_vec());
    end
    done = 4'b0001;
    tick();
    checks++;
    if (grant !== '0) begin
      errors++; $display("FAIL en_done_release got=%b exp=%b", grant, 4'b0000);
    end
    done = '0; SINT = 1; req = '0;
    tick();
  endtask

  task automatic test_reset_midop();
    req = 4'b0100;
    for (int w = 0; w < 6 && grant == '0; w++) tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL rst_mid_setup got=%b exp=%b", grant, 4'b0100);
    end
    SRST = 1;
    tick();
    checks++;
    if (dut_vec !== '0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL rst_mid_clear got=%b exp=%b", dut_vec, {VW{1'b0}});
    end
    SRST = 0; req = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      errors++; $display("FAIL rst_rr_restore got=%b exp=%b", grant, 4'b0001);
    end
    done = 4'b0001; req = '0;
    tick();
    done = '0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      SRST = ($urandom_range(0, 199) == 0);
      SINT = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) begin
        req  = N'($urandom);
        hitm = N'($urandom);
      end
      done = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_cycle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      checks++;
      if ($countones(grant) > 1) begin
        errors++; $display("FAIL rand_onehot cyc=%0d got=%b exp=at most one bit", cyc, grant);
      end
    end
    SRST = 0; SINT = 1; req = '0; hitm = '0; done = '0;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge SCLK);
    test_reset();
    test_basic();
    test_round_robin();
    test_urgent();
    test_timeout();
    test_enable_withdraw();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Parametrised shared-bus arbiter for NPROC snooping caches; generalises the two-cache lock arbiter.
- Grants exclusive bus ownership to one cache at a time.
- Requests flagged as coherence-urgent (the requester holds a modified line that must be written back) have strict priority; round-robin applies within each priority class.
- Adds hold timeout, a bus turnaround cycle and an arbitration enable.

Parameters:
- NPROC, 4, number of requesting caches (2..16).
- MAX_HOLD, 16, maximum owned cycles before forced release (≥2).
- ID_W, $clog2(NPROC), width of grant_id/err_id; derived, not overridden.

Ports:
- SCLK  in  1  clock, all logic on rising edge.
- SRST  in  1  synchronous reset, active-high.
- SINT  in  1  arbitration enable; low blocks new grants, current owner finishes.
- req  in  NPROC  per-cache bus request, level, held until done.
- hitm  in  NPROC  per-cache urgent flag (hit-modified/writeback pending), sampled with req.
- done  in  NPROC  per-cache release pulse; only the owner's bit is honoured.
- grant  out  NPROC  one-hot ownership, registered.
- grant_valid  out  1  OR of grant.
- grant_id  out  ID_W  index of owner; valid only when grant_valid.
- timeout_err  out  1  one-cycle pulse on forced release.
- err_id  out  ID_W  index of the cache last force-released; holds until the next timeout.

Behaviour:
- Reset: SRST sampled high clears grant, grant_valid, grant_id, timeout_err, err_id and the hold counter to 0. State goes to IDLE and rr_ptr to NPROC-1, so cache 0 has first priority. Reset mid-ownership drops grant at that same edge.
- States:
  - IDLE: no grant.
  - OWNED: grant one-hot.
  - TURN: 1-cycle turnaround, grant=0.
- IDLE, SINT=1 and req≠0:
  - Pick the winner at this edge and register the grant. Grant is visible the cycle after req is first seen high (latency 1). Go to OWNED.
- Winner selection:
  - U = req & hitm. If U≠0, choose from U; else choose from req.
  - Within the chosen set, take the first set bit scanning upward from rr_ptr+1 modulo NPROC.
  - rr_ptr ← winner at grant.
- IDLE with SINT=0 or req=0: stay IDLE.
- OWNED, hold counter:
  - The counter resets to 1 on the grant edge and increments each cycle in OWNED.
- OWNED, release:
  - Release occurs if done[owner]=1, or req[owner]=0 (request withdrawn).
  - On release: grant ← 0, next state TURN, no error.
  - done bits of non-owners are ignored.
- OWNED, timeout:
  - If the counter equals MAX_HOLD with no release at that edge, force release: grant ← 0, timeout_err=1 for one cycle, err_id ← owner, go to TURN.
  - Release and timeout at the same edge: release wins, no error.
- TURN: always lasts one cycle, then IDLE. Arbitration restarts from IDLE, so grant-to-grant spacing is at least 2 idle-grant cycles.
- Preemption: none. An urgent request arriving during OWNED waits for release or timeout.
- SINT=0 during OWNED: no effect on the current owner. SINT is only checked in IDLE.
- Invariants: grant is always one-hot or zero; grant_id and grant_valid are consistent with grant in the same cycle.

Test Plan (NPROC=4, MAX_HOLD=8):
1. Basic grant and release: reset, then req=0010 at cycle t → grant=0010, grant_id=1 at t+1. done[1] pulse → grant=0000 next cycle; one TURN cycle; IDLE after.
2. Round-robin: req=1111 held, each owner pulses done one cycle after its grant → grant sequence 0001, 0010, 0100, 1000, 0001, with one zero TURN cycle plus one IDLE cycle between grants.
3. Urgent priority: rr_ptr=0, req=0110, hitm=0100 → grant=0100, not 0010. Then req=0010, hitm=0 → grant=0010 next.
4. Timeout: grant to cache 3, done never asserted, req held → grant drops after 8 owned cycles; timeout_err=1 for exactly one cycle; err_id=3. Same-edge done at count 8 → no timeout_err.
5. Enable and withdrawal: SINT=0 with req=0001 → grant stays 0000. SINT=1 → grant=0001. Owner drops req without done → release, no error. SINT=0 during OWNED → owner keeps grant until done.
6. Reset mid-op: SRST=1 while grant=0100 → all outputs 0 at that edge. After reset, req=1111 → grant=0001 (rr_ptr restored to 3).
